dispatch_stage_nw: RTL and testbench

- Parametrised N-wide successor to the single-lane integer dispatch.
- Registers one rename group per stage, then dispatches its lanes in program order, partially if ROB or int-ISQ credit is short.
- Assigns ROB ids, computes source ready state with same-cycle wakeup and intra-group dependency bypass, and allocates busy bits.
- Sits between rename (IRU) and ROB, int-ISQ and busy_table.

---
 rtl/dispatch_stage_nw_pkg.sv | 15 +
 rtl/dispatch_lane_compact.sv | 28 ++
 rtl/dispatch_stage_nw.sv | 135 +++++++++++++
 tb/tb_dispatch_stage_nw.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/dispatch_stage_nw_pkg.sv
// dispatch_stage_nw_pkg: shared constants and payload field layout for the N-wide dispatch stage
package dispatch_stage_nw_pkg;
  localparam logic [1:0] ROB_STATE_IDLE = 2'd0;
  localparam int PREG_W_DEF = 6;
  localparam int ROBID_W_DEF = 7;
  localparam int PAYLOAD_W_DEF = 256;
  // Payload is opaque to dispatch; these offsets document how ROB/ISQ slice it
  localparam int PL_PC_LSB = 0;
  localparam int PL_INSTR_LSB = 64;
  localparam int PL_LRD_LSB = 96;
  localparam int PL_OLD_PRD_LSB = 101;
  localparam int PL_IMM_LSB = 109;
  localparam int PL_TYPES_LSB = 173;
  localparam int PL_PRED_LSB = 189;
endpackage

// File: rtl/dispatch_lane_compact.sv
// dispatch_lane_compact: picks the k oldest pending lanes and packs them into slots in program order
module dispatch_lane_compact #(
  parameter int WIDTH = 2,
  parameter int CW = $clog2(WIDTH + 1),
  parameter int SEL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0]       pend_mask,
  input  logic [CW-1:0]          k,
  output logic [WIDTH-1:0]       slot_valid,
  output logic [WIDTH*SEL_W-1:0] slot_sel,
  output logic [WIDTH-1:0]       lane_disp
);
  int cnt;
  always_comb begin
    slot_valid = '0;
    slot_sel = '0;
    lane_disp = '0;
    cnt = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (pend_mask[i] && cnt < int'(k)) begin
        slot_valid[cnt] = 1'b1;
        slot_sel[cnt*SEL_W +: SEL_W] = SEL_W'(i);
        lane_disp[i] = 1'b1;
        cnt = cnt + 1;
      end
    end
  end
endmodule

// File: rtl/dispatch_stage_nw.sv
// dispatch_stage_nw: N-wide dispatch stage between rename and ROB/int-ISQ/busy_table
module dispatch_stage_nw import dispatch_stage_nw_pkg::*; #(
  parameter int WIDTH = 2,
  parameter int PREG_W = PREG_W_DEF,
  parameter int ROBID_W = ROBID_W_DEF,
  parameter int PAYLOAD_W = PAYLOAD_W_DEF,
  parameter int CNT_W = 4,
  parameter int WB_PORTS = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             in_valid,
  output logic                         in_ready,
  input  logic [WIDTH*PREG_W-1:0]      in_prs1,
  input  logic [WIDTH*PREG_W-1:0]      in_prs2,
  input  logic [WIDTH*PREG_W-1:0]      in_prd,
  input  logic [WIDTH-1:0]             in_src1_is_reg,
  input  logic [WIDTH-1:0]             in_src2_is_reg,
  input  logic [WIDTH-1:0]             in_need_to_wb,
  input  logic [WIDTH*PAYLOAD_W-1:0]   in_payload,
  input  logic [CNT_W-1:0]             rob_free,
  input  logic [CNT_W-1:0]             isq_free,
  input  logic [1:0]                   rob_state,
  input  logic [ROBID_W-1:0]           rob_tail_robid,
  output logic [WIDTH-1:0]             out_valid,
  output logic [WIDTH*PAYLOAD_W-1:0]   out_payload,
  output logic [WIDTH*PREG_W-1:0]      out_prd,
  output logic [WIDTH-1:0]             out_need_to_wb,
  output logic [WIDTH*ROBID_W-1:0]     out_robid,
  output logic [WIDTH-1:0]             out_src1_state,
  output logic [WIDTH-1:0]             out_src2_state,
  output logic [$clog2(WIDTH+1)-1:0]   disp_count,
  output logic [WIDTH*PREG_W-1:0]      bt_rs1_addr,
  output logic [WIDTH*PREG_W-1:0]      bt_rs2_addr,
  input  logic [WIDTH-1:0]             bt_rs1_busy,
  input  logic [WIDTH-1:0]             bt_rs2_busy,
  output logic [WIDTH-1:0]             bt_alloc_en,
  output logic [WIDTH*PREG_W-1:0]      bt_alloc_rd,
  input  logic [WB_PORTS-1:0]          wb_valid,
  input  logic [WB_PORTS*PREG_W-1:0]   wb_prd,
  input  logic                         flush_valid,
  output logic [31:0]                  stall_cnt
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int SEL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  logic [WIDTH-1:0] pend_mask, st_s1r, st_s2r, st_nwb, slot_valid, lane_disp, s1_busy, s2_busy;
  logic [WIDTH*PREG_W-1:0] st_prs1, st_prs2, st_prd;
  logic [WIDTH*PAYLOAD_W-1:0] st_payload;
  logic [WIDTH*SEL_W-1:0] slot_sel;
  logic [CW-1:0] k;
  logic elig, load;
  int pop, kk, sel;
  assign elig = !reset && pend_mask != '0 && rob_state == ROB_STATE_IDLE && !flush_valid;
  always_comb begin
    pop = 0;
    for (int i = 0; i < WIDTH; i++) pop = pop + int'(pend_mask[i]);
    kk = pop;
    kk = int'(rob_free) < kk ? int'(rob_free) : kk;
    kk = int'(isq_free) < kk ? int'(isq_free) : kk;
    k = elig ? CW'(kk) : '0;
  end
  assign disp_count = k;
  assign in_ready = !reset && !flush_valid && (pend_mask == '0 || int'(k) == pop);
  assign load = in_ready && |in_valid;
  assign bt_rs1_addr = st_prs1;
  assign bt_rs2_addr = st_prs2;
  dispatch_lane_compact #(.WIDTH(WIDTH), .CW(CW), .SEL_W(SEL_W)) u_compact (
    .pend_mask(pend_mask), .k(k), .slot_valid(slot_valid), .slot_sel(slot_sel), .lane_disp(lane_disp)
  );
  // Lowest priority first so later assignments override: busy_table, wakeup, intra-group bypass, non-reg/x0
  always_comb begin
    s1_busy = '0;
    s2_busy = '0;
    for (int i = 0; i < WIDTH; i++) begin
      s1_busy[i] = bt_rs1_busy[i];
      s2_busy[i] = bt_rs2_busy[i];
      for (int w = 0; w < WB_PORTS; w++) begin
        if (wb_valid[w] && wb_prd[w*PREG_W +: PREG_W] == st_prs1[i*PREG_W +: PREG_W]) s1_busy[i] = 1'b0;
        if (wb_valid[w] && wb_prd[w*PREG_W +: PREG_W] == st_prs2[i*PREG_W +: PREG_W]) s2_busy[i] = 1'b0;
      end
      for (int l = 0; l < i; l++) begin
        if (lane_disp[l] && st_nwb[l] && st_prd[l*PREG_W +: PREG_W] == st_prs1[i*PREG_W +: PREG_W]) s1_busy[i] = 1'b1;
        if (lane_disp[l] && st_nwb[l] && st_prd[l*PREG_W +: PREG_W] == st_prs2[i*PREG_W +: PREG_W]) s2_busy[i] = 1'b1;
      end
      if (!st_s1r[i] || st_prs1[i*PREG_W +: PREG_W] == '0) s1_busy[i] = 1'b0;
      if (!st_s2r[i] || st_prs2[i*PREG_W +: PREG_W] == '0) s2_busy[i] = 1'b0;
    end
  end
  always_comb begin
    out_valid = '0;
    out_payload = '0;
    out_prd = '0;
    out_need_to_wb = '0;
    out_robid = '0;
    out_src1_state = '0;
    out_src2_state = '0;
    bt_alloc_en = '0;
    bt_alloc_rd = '0;
    sel = 0;
    for (int j = 0; j < WIDTH; j++) begin
      if (slot_valid[j]) begin
        sel = int'(slot_sel[j*SEL_W +: SEL_W]);
        out_valid[j] = 1'b1;
        out_payload[j*PAYLOAD_W +: PAYLOAD_W] = st_payload[sel*PAYLOAD_W +: PAYLOAD_W];
        out_prd[j*PREG_W +: PREG_W] = st_prd[sel*PREG_W +: PREG_W];
        out_need_to_wb[j] = st_nwb[sel];
        out_robid[j*ROBID_W +: ROBID_W] = rob_tail_robid + ROBID_W'(j);
        out_src1_state[j] = s1_busy[sel];
        out_src2_state[j] = s2_busy[sel];
        bt_alloc_en[j] = st_nwb[sel] && st_prd[sel*PREG_W +: PREG_W] != '0;
        bt_alloc_rd[j*PREG_W +: PREG_W] = st_prd[sel*PREG_W +: PREG_W];
      end
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      pend_mask <= '0;
      stall_cnt <= '0;
    end else begin
      pend_mask <= flush_valid ? '0 : load ? in_valid : pend_mask & ~lane_disp;
      if (pend_mask != '0 && k == '0 && !flush_valid && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
    end
  end
  always_ff @(posedge clock) begin
    if (load) begin
      st_prs1 <= in_prs1;
      st_prs2 <= in_prs2;
      st_prd <= in_prd;
      st_s1r <= in_src1_is_reg;
      st_s2r <= in_src2_is_reg;
      st_nwb <= in_need_to_wb;
      st_payload <= in_payload;
    end
  end
endmodule

// File: tb/tb_dispatch_stage_nw.sv
// tb_dispatch_stage_nw: directed self-checking bench for the 2-wide dispatch stage
module tb_dispatch_stage_nw;
  logic clock, reset, in_ready, flush_valid;
  logic [1:0] in_valid, in_src1_is_reg, in_src2_is_reg, in_need_to_wb, out_valid, out_need_to_wb;
  logic [1:0] out_src1_state, out_src2_state, disp_count, bt_rs1_busy, bt_rs2_busy, bt_alloc_en, wb_valid, rob_state;
  logic [11:0] in_prs1, in_prs2, in_prd, out_prd, bt_rs1_addr, bt_rs2_addr, bt_alloc_rd, wb_prd;
  logic [511:0] in_payload, out_payload;
  logic [3:0] rob_free, isq_free;
  logic [6:0] rob_tail_robid;
  logic [13:0] out_robid;
  logic [31:0] stall_cnt;
  int chk = 0, pass = 0;

  dispatch_stage_nw dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_prs1(in_prs1), .in_prs2(in_prs2), .in_prd(in_prd),
    .in_src1_is_reg(in_src1_is_reg), .in_src2_is_reg(in_src2_is_reg), .in_need_to_wb(in_need_to_wb),
    .in_payload(in_payload), .rob_free(rob_free), .isq_free(isq_free), .rob_state(rob_state),
    .rob_tail_robid(rob_tail_robid), .out_valid(out_valid), .out_payload(out_payload), .out_prd(out_prd),
    .out_need_to_wb(out_need_to_wb), .out_robid(out_robid), .out_src1_state(out_src1_state),
    .out_src2_state(out_src2_state), .disp_count(disp_count), .bt_rs1_addr(bt_rs1_addr),
    .bt_rs2_addr(bt_rs2_addr), .bt_rs1_busy(bt_rs1_busy), .bt_rs2_busy(bt_rs2_busy),
    .bt_alloc_en(bt_alloc_en), .bt_alloc_rd(bt_alloc_rd), .wb_valid(wb_valid), .wb_prd(wb_prd),
    .flush_valid(flush_valid), .stall_cnt(stall_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_in();
    in_valid = '0; in_prs1 = '0; in_prs2 = '0; in_prd = '0;
    in_src1_is_reg = '0; in_src2_is_reg = '0; in_need_to_wb = '0; in_payload = '0;
    rob_free = 4'd4; isq_free = 4'd4; rob_state = 2'd0; rob_tail_robid = '0;
    bt_rs1_busy = '0; bt_rs2_busy = '0; wb_valid = '0; wb_prd = '0; flush_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_in();
    tick();
    chk++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got %0h exp 0", in_ready); else pass++;
    chk++; if (out_valid !== 2'b00) $display("FAIL rst_out_valid got %0h exp 0", out_valid); else pass++;
    chk++; if (disp_count !== 2'd0) $display("FAIL rst_disp_count got %0d exp 0", disp_count); else pass++;
    tick();
    reset = 1'b0;
    #1;
    chk++; if (in_ready !== 1'b1) $display("FAIL post_rst_in_ready got %0h exp 1", in_ready); else pass++;
    chk++; if (stall_cnt !== 32'd0) $display("FAIL post_rst_stall got %0d exp 0", stall_cnt); else pass++;
    chk++; if (bt_alloc_en !== 2'b00) $display("FAIL post_rst_alloc got %0h exp 0", bt_alloc_en); else pass++;
  endtask

  task automatic test_full_dispatch();
    clear_in();
    in_valid = 2'b11; in_prs1 = {6'd2, 6'd1}; in_prd = {6'd4, 6'd3};
    in_src1_is_reg = 2'b11; in_need_to_wb = 2'b11;
    in_payload = {256'hB1, 256'hA0}; rob_tail_robid = 7'h7F;
    #1;
    chk++; if (in_ready !== 1'b1) $display("FAIL full_load_ready got %0h exp 1", in_ready); else pass++;
    tick();
    in_valid = '0;
    #1;
    chk++; if (out_valid !== 2'b11) $display("FAIL full_out_valid got %0h exp 3", out_valid); else pass++;
    chk++; if (out_robid !== {7'h00, 7'h7F}) $display("FAIL full_robid got %0h exp %0h", out_robid, {7'h00, 7'h7F}); else pass++;
    chk++; if (disp_count !== 2'd2) $display("FAIL full_disp_count got %0d exp 2", disp_count); else pass++;
    chk++; if (in_ready !== 1'b1) $display("FAIL full_in_ready got %0h exp 1", in_ready); else pass++;
    chk++; if (out_payload !== {256'hB1, 256'hA0}) $display("FAIL full_payload got %0h exp b1/a0", out_payload); else pass++;
    chk++; if (bt_alloc_en !== 2'b11) $display("FAIL full_alloc_en got %0h exp 3", bt_alloc_en); else pass++;
    chk++; if (bt_alloc_rd !== {6'd4, 6'd3}) $display("FAIL full_alloc_rd got %0h exp %0h", bt_alloc_rd, {6'd4, 6'd3}); else pass++;
    chk++; if (out_src1_state !== 2'b00) $display("FAIL full_src1 got %0h exp 0", out_src1_state); else pass++;
    tick();
    chk++; if (out_valid !== 2'b00) $display("FAIL full_drained got %0h exp 0", out_valid); else pass++;
  endtask

  task automatic test_partial();
    clear_in();
    in_valid = 2'b11; in_prd = {6'd11, 6'd10}; in_need_to_wb = 2'b11;
    isq_free = 4'd1; rob_tail_robid = 7'd20;
    tick();
    in_valid = '0;
    #1;
    chk++; if (out_valid !== 2'b01) $display("FAIL part1_valid got %0h exp 1", out_valid); else pass++;
    chk++; if (out_prd[5:0] !== 6'd10) $display("FAIL part1_prd got %0d exp 10", out_prd[5:0]); else pass++;
    chk++; if (out_robid[6:0] !== 7'd20) $display("FAIL part1_robid got %0d exp 20", out_robid[6:0]); else pass++;
    chk++; if (disp_count !== 2'd1) $display("FAIL part1_count got %0d exp 1", disp_count); else pass++;
    chk++; if (in_ready !== 1'b0) $display("FAIL part1_ready got %0h exp 0", in_ready); else pass++;
    tick();
    rob_tail_robid = 7'd21;
    #1;
    chk++; if (out_valid !== 2'b01) $display("FAIL part2_valid got %0h exp 1", out_valid); else pass++;
    chk++; if (out_prd[5:0] !== 6'd11) $display("FAIL part2_prd got %0d exp 11", out_prd[5:0]); else pass++;
    chk++; if (out_robid[6:0] !== 7'd21) $display("FAIL part2_robid got %0d exp 21", out_robid[6:0]); else pass++;
    chk++; if (in_ready !== 1'b1) $display("FAIL part2_ready got %0h exp 1", in_ready); else pass++;
    tick();
    chk++; if (out_valid !== 2'b00) $display("FAIL part_drained got %0h exp 0", out_valid); else pass++;
  endtask

  task automatic test_bypass();
    clear_in();
    in_valid = 2'b11; in_prs1 = {6'd5, 6'd7}; in_prd = {6'd6, 6'd5};
    in_src1_is_reg = 2'b11; in_need_to_wb = 2'b01;
    tick();
    in_valid = '0;
    #1;
    chk++; if (out_valid !== 2'b11) $display("FAIL byp_valid got %0h exp 3", out_valid); else pass++;
    chk++; if (out_src1_state !== 2'b10) $display("FAIL byp_src1 got %0h exp 2", out_src1_state); else pass++;
    chk++; if (bt_alloc_en !== 2'b01) $display("FAIL byp_alloc got %0h exp 1", bt_alloc_en); else pass++;
    tick();
    in_valid = 2'b11; isq_free = 4'd1;
    tick();
    in_valid = '0;
    #1;
    chk++; if (out_valid !== 2'b01) $display("FAIL split1_valid got %0h exp 1", out_valid); else pass++;
    chk++; if (out_src1_state !== 2'b00) $display("FAIL split1_src1 got %0h exp 0", out_src1_state); else pass++;
    tick();
    wb_valid = 2'b01; wb_prd = {6'd0, 6'd5}; bt_rs1_busy = 2'b10;
    #1;
    chk++; if (bt_rs1_addr[11:6] !== 6'd5) $display("FAIL split2_addr got %0d exp 5", bt_rs1_addr[11:6]); else pass++;
    chk++; if (out_valid !== 2'b01) $display("FAIL split2_valid got %0h exp 1", out_valid); else pass++;
    chk++; if (out_src1_state !== 2'b00) $display("FAIL split2_wb_src1 got %0h exp 0", out_src1_state); else pass++;
    wb_valid = 2'b00;
    #1;
    chk++; if (out_src1_state !== 2'b01) $display("FAIL split2_bt_src1 got %0h exp 1", out_src1_state); else pass++;
    tick();
  endtask

  task automatic test_wakeup();
    clear_in();
    in_valid = 2'b11; in_prs1 = {6'd0, 6'd0}; in_prs2 = {6'd8, 6'd9}; in_prd = {6'd12, 6'd0};
    in_src1_is_reg = 2'b10; in_src2_is_reg = 2'b11; in_need_to_wb = 2'b11;
    tick();
    in_valid = '0; wb_valid = 2'b10; wb_prd = {6'd9, 6'd0};
    bt_rs1_busy = 2'b11; bt_rs2_busy = 2'b11;
    #1;
    chk++; if (out_src2_state !== 2'b10) $display("FAIL wk_src2 got %0h exp 2", out_src2_state); else pass++;
    chk++; if (out_src1_state !== 2'b00) $display("FAIL wk_src1 got %0h exp 0", out_src1_state); else pass++;
    chk++; if (bt_alloc_en !== 2'b10) $display("FAIL wk_alloc_en got %0h exp 2", bt_alloc_en); else pass++;
    chk++; if (bt_alloc_rd[11:6] !== 6'd12) $display("FAIL wk_alloc_rd got %0d exp 12", bt_alloc_rd[11:6]); else pass++;
    tick();
  endtask

  task automatic test_stall_flush();
    clear_in();
    rob_state = 2'd1; in_valid = 2'b11; in_prd = {6'd2, 6'd1}; in_need_to_wb = 2'b11;
    tick();
    in_valid = '0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk++; if (out_valid !== 2'b00) $display("FAIL stall_valid[%0d] got %0h exp 0", c, out_valid); else pass++;
      tick();
    end
    chk++; if (stall_cnt !== 32'd3) $display("FAIL stall_cnt got %0d exp 3", stall_cnt); else pass++;
    flush_valid = 1'b1; rob_state = 2'd0; in_valid = 2'b11;
    #1;
    chk++; if (out_valid !== 2'b00) $display("FAIL flush_valid_out got %0h exp 0", out_valid); else pass++;
    chk++; if (bt_alloc_en !== 2'b00) $display("FAIL flush_alloc got %0h exp 0", bt_alloc_en); else pass++;
    chk++; if (in_ready !== 1'b0) $display("FAIL flush_ready got %0h exp 0", in_ready); else pass++;
    tick();
    flush_valid = 1'b0; in_valid = '0;
    #1;
    chk++; if (out_valid !== 2'b00) $display("FAIL post_flush_valid got %0h exp 0", out_valid); else pass++;
    chk++; if (in_ready !== 1'b1) $display("FAIL post_flush_ready got %0h exp 1", in_ready); else pass++;
    chk++; if (stall_cnt !== 32'd3) $display("FAIL post_flush_stall got %0d exp 3", stall_cnt); else pass++;
  endtask

  task automatic test_reset_hold();
    clear_in();
    rob_state = 2'd1; in_valid = 2'b11; in_prd = {6'd2, 6'd1}; in_need_to_wb = 2'b11;
    tick();
    in_valid = '0;
    tick();
    reset = 1'b1; rob_state = 2'd0;
    #1;
    chk++; if (out_valid !== 2'b00) $display("FAIL rsth_valid got %0h exp 0", out_valid); else pass++;
    chk++; if (in_ready !== 1'b0) $display("FAIL rsth_ready got %0h exp 0", in_ready); else pass++;
    tick();
    reset = 1'b0;
    #1;
    chk++; if (out_valid !== 2'b00) $display("FAIL rsth_after_valid got %0h exp 0", out_valid); else pass++;
    chk++; if (stall_cnt !== 32'd0) $display("FAIL rsth_stall got %0d exp 0", stall_cnt); else pass++;
    chk++; if (disp_count !== 2'd0) $display("FAIL rsth_count got %0d exp 0", disp_count); else pass++;
    chk++; if (bt_alloc_en !== 2'b00) $display("FAIL rsth_alloc got %0h exp 0", bt_alloc_en); else pass++;
    chk++; if (in_ready !== 1'b1) $display("FAIL rsth_ready_after got %0h exp 1", in_ready); else pass++;
  endtask

  initial begin
    test_reset();
    test_full_dispatch();
    test_partial();
    test_bypass();
    test_wakeup();
    test_stall_flush();
    test_reset_hold();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end
endmodule
